// File: rtl/up_pkg.sv
// up_pkg: shared widths, opcode/section encodings and the
// fetch-state type for the micro-processor pipeline.
`ifndef PM_ID_INS_WIDTH
`define PM_ID_INS_WIDTH 13
`endif

package up_pkg;

  localparam int PC_WIDTH_DEF  = 8;
  localparam int INS_WIDTH_DEF = `PM_ID_INS_WIDTH;
  localparam int OPC_WIDTH     = 5;

  // opcode lives in the top OPC_WIDTH bits of a word
  localparam logic [OPC_WIDTH-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPC_WIDTH-1:0] OP_SUB  = 5'b00001;
  localparam logic [OPC_WIDTH-1:0] OP_LD   = 5'b01000;
  localparam logic [OPC_WIDTH-1:0] OP_ST   = 5'b01001;
  localparam logic [OPC_WIDTH-1:0] OP_JMP  = 5'b10000;
  localparam logic [OPC_WIDTH-1:0] OP_NOP  = 5'b11111;

  localparam logic [1:0] SEC_ALU = 2'b00;
  localparam logic [1:0] SEC_MEM = 2'b01;
  localparam logic [1:0] SEC_CTL = 2'b10;
  localparam logic [1:0] SEC_SYS = 2'b11;

  // opcode 11111 with every enable bit clear
  localparam logic [INS_WIDTH_DEF-1:0] NOP_INS = 13'h1F00;

  typedef enum logic [1:0] {
    FS_START,
    FS_RUN,
    FS_STALL,
    FS_REDIRECT
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: program-memory port plus the
// decoder-side stall/jump controls and instruction output.
interface instruction_fetch_if
  import up_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int INS_WIDTH = INS_WIDTH_DEF
);

  logic [PC_WIDTH-1:0]  PM_Addr;
  logic [INS_WIDTH-1:0] PM_Data;
  logic                 Stall;
  logic                 Jump;
  logic [PC_WIDTH-1:0]  JumpAddr;
  logic [INS_WIDTH-1:0] Ins;
  logic                 Ins_Valid;
  logic [PC_WIDTH-1:0]  Ins_PC;

  modport master (
    output PM_Addr,
    input  PM_Data,
    input  Stall,
    input  Jump,
    input  JumpAddr,
    output Ins,
    output Ins_Valid,
    output Ins_PC
  );

  modport slave (
    input  PM_Addr,
    output PM_Data,
    output Stall,
    output Jump,
    output JumpAddr,
    input  Ins,
    input  Ins_Valid,
    input  Ins_PC
  );

endinterface

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding register that parks the
// in-flight fetch word while the decoder stalls.
module fetch_skid #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  // clear beats load, load beats take
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer for a synchronous program
// memory; FETCH_SKID_EN selects a zero-bubble stall buffer.
module instruction_fetch
  import up_pkg::*;
#(
  parameter int PC_WIDTH  = 8,
  parameter int INS_WIDTH = `PM_ID_INS_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  instruction_fetch_if.master bus
);

  localparam logic [INS_WIDTH-1:0] NOP =
    INS_WIDTH'(NOP_INS);

  fetch_state_e         state;
  logic [PC_WIDTH-1:0]  fpc;
  logic [PC_WIDTH-1:0]  issued_addr;
  logic                 pending;
  logic [INS_WIDTH-1:0] ins_q;
  logic                 ins_valid_q;
  logic [PC_WIDTH-1:0]  ins_pc_q;

  logic                 skid_full;
  logic [INS_WIDTH-1:0] skid_ins;
  logic [PC_WIDTH-1:0]  skid_pc;

  assign bus.PM_Addr   = fpc;
  assign bus.Ins       = ins_q;
  assign bus.Ins_Valid = ins_valid_q;
  assign bus.Ins_PC    = ins_pc_q;

`ifdef FETCH_SKID_EN
  logic                          skid_load;
  logic                          skid_take;
  logic [INS_WIDTH+PC_WIDTH-1:0] skid_q;

  assign skid_load = bus.Stall &&
                     state != FS_STALL &&
                     pending;
  assign skid_take = !bus.Stall &&
                     state == FS_STALL;
  assign {skid_ins, skid_pc} = skid_q;

  fetch_skid #(
    .W (INS_WIDTH + PC_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.Jump),
    .load  (skid_load),
    .take  (skid_take),
    .d     ({bus.PM_Data, issued_addr}),
    .q     (skid_q),
    .full  (skid_full)
  );
`else
  assign skid_full = 1'b0;
  assign skid_ins  = NOP;
  assign skid_pc   = '0;
`endif

  // fetch sequencer: reset > jump > stall > advance
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FS_START;
      fpc         <= '0;
      issued_addr <= '0;
      pending     <= 1'b0;
      ins_q       <= NOP;
      ins_valid_q <= 1'b0;
      ins_pc_q    <= '0;
    end else if (bus.Jump) begin
      state       <= FS_REDIRECT;
      fpc         <= bus.JumpAddr;
      pending     <= 1'b0;
      ins_q       <= NOP;
      ins_valid_q <= 1'b0;
    end else if (bus.Stall) begin
      if (state != FS_STALL) begin
`ifndef FETCH_SKID_EN
        // drop the in-flight word, re-issue it later
        if (pending) begin
          fpc <= issued_addr;
        end
`endif
        pending <= 1'b0;
      end
      state <= FS_STALL;
    end else begin
      if (state == FS_STALL) begin
        ins_q       <= skid_full ? skid_ins : NOP;
        ins_valid_q <= skid_full;
        ins_pc_q    <= skid_full ? skid_pc : ins_pc_q;
      end else begin
        ins_q       <= pending ? bus.PM_Data : NOP;
        ins_valid_q <= pending;
        ins_pc_q    <= issued_addr;
      end
      issued_addr <= fpc;
      pending     <= 1'b1;
      fpc         <= fpc + PC_WIDTH'(1);
      state       <= FS_RUN;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table, corner
// sequences and a randomized program-order reference check.
module tb_instruction_fetch;
  import up_pkg::*;

  localparam int PW = 8;
  localparam int IW = 13;
`ifdef FETCH_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [IW-1:0] NOP = NOP_INS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if #(
    .PC_WIDTH  (PW),
    .INS_WIDTH (IW)
  ) bus ();

  instruction_fetch #(
    .PC_WIDTH  (PW),
    .INS_WIDTH (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [IW-1:0] mem [256];

  always @(posedge clk) bus.PM_Data <= mem[bus.PM_Addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit s,
                       input bit j, input logic [7:0] ja);
    rst          = r;
    bus.Stall    = s;
    bus.Jump     = j;
    bus.JumpAddr = ja;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         r;
    bit         s;
    bit         j;
    logic [7:0] ja;
    bit         v;
    logic [7:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit s, bit j,
                              logic [7:0] ja, bit v,
                              logic [7:0] pc);
    vec_t e;
    e.r = r; e.s = s; e.j = j;
    e.ja = ja; e.v = v; e.pc = pc;
    tbl.push_back(e);
  endfunction

  task automatic chk_out(input string tag, input bit v,
                         input logic [7:0] pc);
    chk({tag, " valid"}, 32'(bus.Ins_Valid), 32'(v));
    chk({tag, " ins"}, 32'(bus.Ins),
        32'(v ? mem[pc] : NOP));
    if (v) chk({tag, " pc"}, 32'(bus.Ins_PC), 32'(pc));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"}, 32'(bus.Ins_Valid), 32'(0));
    chk({tag, " ins"}, 32'(bus.Ins), 32'(NOP));
    chk({tag, " pc"}, 32'(bus.Ins_PC), 32'(0));
    chk({tag, " addr"}, 32'(bus.PM_Addr), 32'(0));
  endtask

  logic [7:0]  nxt;
  int          bub;
  logic [IW-1:0] p_ins;
  logic        p_v;
  logic [7:0]  p_pc;
  bit          rr, rs, rj;
  logic [7:0]  rja;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
    rst = 1'b1;
    bus.Stall = 1'b0;
    bus.Jump = 1'b0;
    bus.JumpAddr = '0;

    // reset and fill
    add(1,0,0,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 0,8'h00);
    for (int i = 0; i < 4; i++) add(0,0,0,0, 1,8'(i));
    // 3-cycle stall while B shown
    add(0,0,1,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 1,8'h00);
    add(0,0,0,8'h00, 1,8'h01);
    for (int i = 0; i < 3; i++) add(0,1,0,0, 1,8'h01);
    add(0,0,0,8'h00, SKID,8'h02);
    add(0,0,0,8'h00, 1,SKID ? 8'h03 : 8'h02);
    add(0,0,0,8'h00, 1,SKID ? 8'h04 : 8'h03);
    // jump to 40 while Ins_PC=2
    add(0,0,1,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 1,8'h00);
    add(0,0,0,8'h00, 1,8'h01);
    add(0,0,0,8'h00, 1,8'h02);
    add(0,0,1,8'h40, 0,8'h00);
    add(0,0,0,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 1,8'h40);
    add(0,0,0,8'h00, 1,8'h41);
    // jump and stall together
    add(0,1,1,8'h80, 0,8'h00);
    add(0,1,0,8'h00, 0,8'h00);
    add(0,1,0,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 1,8'h80);
    add(0,0,0,8'h00, 1,8'h81);
    // wrap
    add(0,0,1,8'hFE, 0,8'h00);
    add(0,0,0,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 1,8'hFE);
    add(0,0,0,8'h00, 1,8'hFF);
    add(0,0,0,8'h00, 1,8'h00);
    add(0,0,0,8'h00, 1,8'h01);
    // reset mid-stall
    add(0,1,0,8'h00, 1,8'h01);
    add(0,1,0,8'h00, 1,8'h01);
    add(1,1,0,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 0,8'h00);
    add(0,0,0,8'h00, 1,8'h00);
    add(0,0,0,8'h00, 1,8'h01);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].j, tbl[i].ja);
      if (tbl[i].r) chk_reset($sformatf("vec%0d", i));
      else chk_out($sformatf("vec%0d", i),
                   tbl[i].v, tbl[i].pc);
    end

    // reset during the redirect cycle
    drive(0,0,1,8'h33);
    drive(1,0,0,8'h00);
    chk_reset("rst_redir");
    drive(0,0,0,8'h00);
    chk_out("rst_redir c1", 0, 8'h00);
    drive(0,0,0,8'h00);
    chk_out("rst_redir c2", 1, 8'h00);
    drive(0,0,0,8'h00);
    chk_out("rst_redir c3", 1, 8'h01);

    // jump while stalled must flush any parked word
    drive(0,1,0,8'h00);
    chk_out("jmp_stall s1", 1, 8'h01);
    drive(0,1,0,8'h00);
    chk_out("jmp_stall s2", 1, 8'h01);
    drive(0,1,1,8'h20);
    chk_out("jmp_stall j", 0, 8'h00);
    drive(0,1,0,8'h00);
    chk_out("jmp_stall s3", 0, 8'h00);
    drive(0,0,0,8'h00);
    chk_out("jmp_stall rel", 0, 8'h00);
    drive(0,0,0,8'h00);
    chk_out("jmp_stall tgt", 1, 8'h20);
    drive(0,0,0,8'h00);
    chk_out("jmp_stall tgt1", 1, 8'h21);

    // random: outputs must follow program order
    drive(1,0,0,8'h00);
    chk_reset("rnd start");
    nxt = 8'h00;
    bub = 0;
    for (int c = 0; c < 3000; c++) begin
      rr  = ($urandom_range(199) == 0);
      rs  = ($urandom_range(99) < 30);
      rj  = ($urandom_range(99) < 6);
      rja = 8'($urandom);
      p_ins = bus.Ins;
      p_v   = bus.Ins_Valid;
      p_pc  = bus.Ins_PC;
      drive(rr, rs, rj, rja);
      if (rr) begin
        chk_reset("rnd rst");
        nxt = 8'h00;
        bub = 0;
      end else if (rj) begin
        chk("rnd jump valid", 32'(bus.Ins_Valid), 32'(0));
        chk("rnd jump ins", 32'(bus.Ins), 32'(NOP));
        nxt = rja;
        bub = 0;
      end else if (rs) begin
        chk("rnd hold", {bus.Ins, bus.Ins_Valid,
                         bus.Ins_PC},
            {p_ins, p_v, p_pc});
        bub = 0;
      end else if (bus.Ins_Valid) begin
        chk("rnd pc", 32'(bus.Ins_PC), 32'(nxt));
        chk("rnd ins", 32'(bus.Ins), 32'(mem[nxt]));
        nxt = nxt + 8'h01;
        bub = 0;
      end else begin
        bub++;
        chk("rnd bubble ins", 32'(bus.Ins), 32'(NOP));
        chk("rnd bubble run", 32'(bub <= 1), 32'(1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program-memory address width.
REQ-002 SHALL have parameter INS_WIDTH, default `PM_ID_INS_WIDTH (13), instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port PM_Addr  output  PC_WIDTH  address to synchronous program memory.
REQ-006 SHALL have port PM_Data  input  INS_WIDTH  word addressed by PM_Addr one cycle earlier.
REQ-007 SHALL have port Stall  input  1  decoder stage cannot accept a new instruction; hold outputs.
REQ-008 SHALL have port Jump  input  1  redirect fetch to JumpAddr.
REQ-009 SHALL have port JumpAddr  input  PC_WIDTH  redirect target.
REQ-010 SHALL have port Ins  output  INS_WIDTH  instruction to InstructionDecoder.Ins.
REQ-011 SHALL have port Ins_Valid  output  1  Ins holds a real fetched word.
REQ-012 SHALL have port Ins_PC  output  PC_WIDTH  address Ins was fetched from.

Function
REQ-013 SHALL keep fetch PC (FPC) driving PM_Addr directly, plus IssuedAddr and Pending flag for the word arriving on PM_Data.
REQ-014 SHALL implement states FS_START (post-reset, nothing pending), FS_RUN, FS_STALL, FS_REDIRECT.
REQ-015 SHALL, in FS_RUN without Stall/Jump: FPC <= FPC+1, Ins <= PM_Data, Ins_Valid <= Pending, Ins_PC <= IssuedAddr; one instruction per cycle.
REQ-016 SHALL wrap FPC from 2^PC_WIDTH-1 to 0 silently; no flag.
REQ-017 SHALL, while Stall=1, hold Ins, Ins_Valid, Ins_PC unchanged; enter FS_STALL; leave to FS_RUN the cycle after Stall falls.
REQ-018 SHALL give Jump priority over Stall: FPC <= JumpAddr, Pending <= 0, Ins_Valid <= 0, in-flight word discarded, state FS_REDIRECT for one cycle then FS_RUN.
REQ-019 SHALL drive Ins = NOP_INS whenever Ins_Valid=0, so the combinational decoder asserts no write/CE enables.
REQ-020 SHALL latency: first word at 0 -> Ins_Valid=1 in 2nd cycle after rst falls; after Jump, target word valid 2 cycles after the Jump cycle.
REQ-021 SHALL never duplicate or skip an instruction across any Stall/Jump combination.

Reset
REQ-022 SHALL, on rst=1 at clk edge, set FPC=0, PM_Addr=0, IssuedAddr=0, Pending=0, Ins=NOP_INS, Ins_Valid=0, Ins_PC=0, skid empty, state FS_START.
REQ-023 SHALL let rst override Stall and Jump, including mid-stall or mid-redirect.

Configuration
REQ-024 SHALL use macro FETCH_SKID_EN.
REQ-025 SHALL, with FETCH_SKID_EN defined: one-entry skid buffer captures the pending word on stall entry, FPC frozen; on release Ins takes skid contents next edge; zero-bubble stall.
REQ-026 SHALL, without FETCH_SKID_EN: on stall entry FPC <= IssuedAddr (re-issue), Pending <= 0; on release the word is refetched; exactly one bubble (Ins_Valid=0 one cycle) after each stall.
REQ-027 SHALL clear the skid on Jump and rst.

Structure
REQ-028 SHALL place fetch-state enum, NOP_INS (13'h1F00, opcode 11111, no enables) and default widths in shared package up_pkg with the existing opcode/section defines.
REQ-029 SHALL use sub-module fetch_skid (one-entry buffer: load, take, clear, full) instantiated only under FETCH_SKID_EN.

Verification
REQ-030 SHALL test reset fill: mem[0..3]=A,B,C,D, release rst -> cycles 2..5 Ins=A,B,C,D, Ins_PC=0..3, Ins_Valid=1.
REQ-031 SHALL test 3-cycle Stall while Ins=B -> Ins=B held; then C; with skid no bubble, without skid exactly one Ins_Valid=0 (Ins=NOP_INS) cycle before C.
REQ-032 SHALL test Jump to 8'h40 at Ins_PC=2 -> word at 3 never valid; Ins_PC=8'h40 two cycles later.
REQ-033 SHALL test Jump and Stall same cycle -> redirect taken, outputs invalid, target delivered after Stall falls.
REQ-034 SHALL test wrap: Jump to 8'hFE -> Ins_PC sequence FE, FF, 00, 01.
REQ-035 SHALL test rst asserted mid-stall with skid full -> next cycle all outputs at reset values, refetch from 0.
